// File: rtl/exc_mem_unit_pkg.sv
// Shared constants and types for the memory-stage exception unit.
package exc_mem_unit_pkg;

    localparam int unsigned EXC_W  = 5;
    localparam int unsigned ADDR_W = 32;

    // ExcCode values
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_DBE  = 5'd7;

    // Access size encodings (2'd3 is illegal)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Default device window bases
    localparam logic [ADDR_W-1:0] DEF_DEV0_BASE = 32'h0000_7f00;
    localparam logic [ADDR_W-1:0] DEF_DEV1_BASE = 32'h0000_7f10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dev_state_e;

    // Payload toward W/CP0
    typedef struct packed {
        logic [EXC_W-1:0]  code;
        logic [ADDR_W-1:0] bad;
    } exc_rec_t;

    // Address-error code for the current access direction
    function automatic logic [EXC_W-1:0] ad_code(input logic is_st);
        return is_st ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/exc_dev_window.sv
// Decodes one device window: hit, word index inside the window, store-protected word.
module exc_dev_window
    import exc_mem_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE     = DEF_DEV0_BASE,
    parameter logic [3:0]        WORDS    = 4'd3,
    parameter logic [3:0]        RO_WMASK = 4'b0000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [3:0]        word_idx,
    output logic              ro_hit
);

    localparam logic [ADDR_W-1:0] SPAN = {26'd0, WORDS, 2'b00};

    logic [ADDR_W-1:0] offset;

    // Offset-based range check avoids overflow of base + span
    always_comb begin
        offset   = addr - BASE;
        hit      = (addr >= BASE) && (offset < SPAN);
        word_idx = offset[5:2];
        ro_hit   = hit && (word_idx < 4'd4) && RO_WMASK[word_idx[1:0]];
    end

endmodule

// File: rtl/exc_mem_unit.sv
// M-stage exception unit: alignment/legality checks, device handshake with watchdog, output register.
module exc_mem_unit
    import exc_mem_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0]      MEM_LIMIT    = 32'h0000_3000,
    parameter int unsigned            N_DEV        = 2,
    parameter logic [N_DEV*32-1:0]    DEV_BASE     = {DEF_DEV1_BASE, DEF_DEV0_BASE},
    parameter logic [N_DEV*4-1:0]     DEV_WORDS    = {4'd3, 4'd3},
    parameter logic [N_DEV*4-1:0]     DEV_RO_WMASK = {4'b0100, 4'b0100},
    parameter int unsigned            TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic              st,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [EXC_W-1:0]  exc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              dev_ack,
    output logic              dev_req,
    output logic [N_DEV-1:0]  dev_sel,
    output logic              busy,
    output logic [EXC_W-1:0]  exc_out,
    output logic [ADDR_W-1:0] badvaddr_out
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [N_DEV-1:0] hit;
    logic [N_DEV-1:0] ro_hit;
    logic [3:0]       word_idx [N_DEV];

    logic [N_DEV-1:0] win_sel;
    logic             win_ro;
    logic             any_hit;
    logic [3:0]       win_word;
    logic [3:0]       win_words;

    logic             misalign;
    logic             dev_go;
    exc_rec_t         res;
    exc_rec_t         cap;
    exc_rec_t         out_q;

    dev_state_e       state;
    dev_state_e       state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             tmo;
    logic             tmo_next;
    logic [N_DEV-1:0] sel_next;

    for (genvar i = 0; i < N_DEV; i++) begin : g_dev
        exc_dev_window #(
            .BASE     (DEV_BASE[32*i +: 32]),
            .WORDS    (DEV_WORDS[4*i +: 4]),
            .RO_WMASK (DEV_RO_WMASK[4*i +: 4])
        ) u_win (
            .addr     (addr),
            .hit      (hit[i]),
            .word_idx (word_idx[i]),
            .ro_hit   (ro_hit[i])
        );
    end

    // Pick the lowest-index hitting window
    always_comb begin
        win_sel   = '0;
        win_ro    = 1'b0;
        any_hit   = 1'b0;
        win_word  = '0;
        win_words = '0;
        for (int i = int'(N_DEV) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_sel   = N_DEV'(1) << i;
                win_ro    = ro_hit[i];
                any_hit   = 1'b1;
                win_word  = word_idx[i];
                win_words = DEV_WORDS[4*i +: 4];
            end
        end
        if (any_hit) begin
            assert (win_word < win_words);
        end
    end

    // First-match access check
    always_comb begin
        res      = '{code: exc_in, bad: '0};
        dev_go   = 1'b0;
        misalign = ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
                   ((size == SIZE_HALF) && addr[0]) ||
                   (size == 2'd3);
        if (ld || st) begin
            if (exc_in != EXC_NONE) begin
                res.code = exc_in;
            end else if (misalign) begin
                res = '{code: ad_code(st), bad: addr};
            end else if (addr < MEM_LIMIT) begin
                res.code = EXC_NONE;
            end else if (any_hit) begin
                if (size != SIZE_WORD) begin
                    res = '{code: ad_code(st), bad: addr};
                end else if (st && win_ro) begin
                    res = '{code: EXC_ADES, bad: addr};
                end else begin
                    dev_go = 1'b1;
                end
            end else begin
                res = '{code: ad_code(st), bad: addr};
            end
        end
    end

    // Device handshake next-state and busy
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tmo_next   = tmo;
        sel_next   = dev_sel;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dev_go && !flush) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                    tmo_next   = 1'b0;
                    sel_next   = win_sel;
                    busy       = 1'b1;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                    sel_next   = '0;
                end else if (dev_ack) begin
                    state_next = ST_DONE;
                    tmo_next   = 1'b0;
                    sel_next   = '0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_next = ST_DONE;
                    tmo_next   = 1'b1;
                    sel_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // busy must drop as soon as reset is seen, not at the next edge
        if (reset) begin
            busy = 1'b0;
        end
    end

    // Handshake state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tmo     <= 1'b0;
            dev_sel <= '0;
            dev_req <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            tmo     <= tmo_next;
            dev_sel <= sel_next;
            dev_req <= (state_next == ST_WAIT);
        end
    end

    // Completed device access replaces the combinational result
    always_comb begin
        cap = res;
        if (state == ST_DONE) begin
            cap = '{code: tmo ? EXC_DBE : EXC_NONE, bad: tmo ? addr : '0};
        end
    end

    // Output register toward W/CP0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (flush) begin
            out_q <= '0;
        end else if (!(stall || busy)) begin
            out_q <= cap;
        end
    end

    assign exc_out      = out_q.code;
    assign badvaddr_out = out_q.bad;

endmodule
